// File: rtl/noc_pkg.sv
// noc_pkg: direction constants and port-index width helper shared by switch blocks
package noc_pkg;
    localparam int NORTH = 0;
    localparam int SOUTH = 1;
    localparam int WEST  = 2;
    localparam int EAST  = 3;
    function automatic int PORT_IDX_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req: request vector, ptr: search start index
//   gnt: one-hot grant, idx: granted index, any: some request present
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [N-1:0] hi;
    always_comb begin
        hi  = '0;
        gnt = '0;
        idx = '0;
        any = |req;
        for (int k = 0; k < N; k++) hi[k] = req[k] && (k >= int'(ptr));
        // lowest requester at or above ptr, else wrap to the lowest requester overall
        for (int k = N - 1; k >= 0; k--) if ((hi != '0) ? hi[k] : req[k]) idx = W'(k);
        for (int k = 0; k < N; k++) gnt[k] = any && (idx == W'(k));
    end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin route reservation held until the owner relieves
//   routeReserveRequestValid/routeReserveRequest: per-input request and target output
//   routeRelieve: per-input release of the held output
//   routeReserveStatus: per-input ownership level
//   outputSelect/outputBusy: per-output crossbar select and lock
module switch_allocator
    import noc_pkg::*;
#(
    parameter int N             = 4,
    parameter int REQUEST_WIDTH = PORT_IDX_W(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               routeReserveRequestValid,
    input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [N-1:0]               routeRelieve,
    output logic [N-1:0]               routeReserveStatus,
    output logic [N*REQUEST_WIDTH-1:0] outputSelect,
    output logic [N-1:0]               outputBusy
);
    localparam int W = REQUEST_WIDTH;
    logic [N-1:0] locked, holding, any, freed, granted;
    logic [W-1:0] owner [N];
    logic [W-1:0] ptr   [N];
    logic [W-1:0] held  [N];
    logic [W-1:0] win   [N];
    logic [N-1:0] elig  [N];
    logic [N-1:0] gnt   [N];
    // only FREE outputs see requests, so a same-cycle relieve cannot be reused until next cycle;
    // indices >= N never match any output and are dropped here
    always_comb begin
        freed   = '0;
        granted = '0;
        for (int o = 0; o < N; o++) begin
            elig[o] = '0;
            for (int i = 0; i < N; i++) begin
                elig[o][i] = routeReserveRequestValid[i] && !holding[i] && !locked[o]
                             && (routeReserveRequest[i*W +: W] == W'(o));
                freed[o]   = freed[o] || (holding[i] && routeRelieve[i] && (held[i] == W'(o)));
                granted[i] = granted[i] || gnt[o][i];
            end
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_out
        rr_arbiter #(.N(N), .W(W)) u_arb (
            .req(elig[g]),
            .ptr(ptr[g]),
            .gnt(gnt[g]),
            .idx(win[g]),
            .any(any[g])
        );
        assign outputSelect[g*W +: W] = owner[g];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            locked  <= '0;
            holding <= '0;
            for (int k = 0; k < N; k++) begin
                owner[k] <= '0;
                ptr[k]   <= '0;
                held[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (any[k]) begin
                    locked[k] <= 1'b1;
                    owner[k]  <= win[k];
                    ptr[k]    <= (int'(win[k]) == N - 1) ? '0 : win[k] + 1'b1;
                end else if (freed[k]) begin
                    locked[k] <= 1'b0;
                end
                if (granted[k]) begin
                    holding[k] <= 1'b1;
                    held[k]    <= routeReserveRequest[k*W +: W];
                end else if (holding[k] && routeRelieve[k]) begin
                    holding[k] <= 1'b0;
                end
            end
        end
    end
    assign routeReserveStatus = holding;
    assign outputBusy         = locked;
endmodule
